// File: rtl/switch_input_conditioner.sv
// switch_input_conditioner
// Synchronises and debounces 16 board switches plus the "enter" key, presents
// the stable switch word, and latches a switch snapshot on every key press into
// a valid/ack holding register for the processor's input instruction.
// Optional build macro: KEY_REPEAT_EN adds auto-repeat press events while the
// key is held (REPEAT_DELAY ticks to the first repeat, then one per REPEAT_RATE).
module switch_input_conditioner #(
  parameter int TICK_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 10,
  parameter int KEY_ACTIVE_LOW = 1
`ifdef KEY_REPEAT_EN
  ,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_RATE    = 100
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] sw_raw,
  input  logic        key_raw,
  output logic [15:0] sw,
  output logic        key_pressed,
  output logic [15:0] data_out,
  output logic        data_valid,
  input  logic        data_ack,
  output logic        overrun
);

  // 16 switch channels plus the key on channel 16
  localparam int NCH   = 17;
  localparam int KEY   = 16;
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_TICKS);

  logic [NCH-1:0]   r_sync1;
  logic [NCH-1:0]   r_sync2;
  logic [NCH-1:0]   w_sample;
  logic [NCH-1:0]   w_stable;
  logic [PRE_W-1:0] r_presc;
  logic             w_tick;
  logic             r_key_prev;
  logic             w_press;
  logic             w_event;
  logic [15:0]      r_data_out;
  logic             r_data_valid;
  logic             r_overrun;

  // Two-flop synchroniser for every raw channel
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {key_raw, sw_raw};
      r_sync2 <= r_sync1;
    end
  end

  // Key is normalised after the synchroniser so that 1 always means pressed
  assign w_sample = {((KEY_ACTIVE_LOW != 0) ? ~r_sync2[KEY] : r_sync2[KEY]),
                     r_sync2[15:0]};

  // Free-running sample prescaler, wraps after TICK_DIV cycles
  always_ff @(posedge clock) begin
    if (reset) begin
      r_presc <= '0;
    end else if (r_presc == PRE_LAST) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  assign w_tick = (r_presc == PRE_LAST);

  // One debounce counter per channel; the stable level flips only after
  // DEBOUNCE_TICKS consecutive tick samples that disagree with it
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      logic [CNT_W-1:0] r_cnt;
      logic             r_stable;
      logic [CNT_W-1:0] w_cnt_inc;

      assign w_cnt_inc = r_cnt + 1'b1;

      // Count disagreeing samples; any agreeing sample restarts the run
      always_ff @(posedge clock) begin
        if (reset) begin
          r_cnt    <= '0;
          r_stable <= 1'b0;
        end else if (w_tick) begin
          if (w_sample[gi] == r_stable) begin
            r_cnt <= '0;
          end else if (w_cnt_inc == CNT_DONE) begin
            r_stable <= w_sample[gi];
            r_cnt    <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
      end

      assign w_stable[gi] = r_stable;
    end
  endgenerate

  // Previous debounced key level for rising-edge (press) detection
  always_ff @(posedge clock) begin
    if (reset) begin
      r_key_prev <= 1'b0;
    end else begin
      r_key_prev <= w_stable[KEY];
    end
  end

  // Release produces no event, only the 0->1 transition does
  assign w_press = w_stable[KEY] & ~r_key_prev;

`ifdef KEY_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] r_rep_cnt;
  logic             r_rep_armed;
  logic [REP_W-1:0] w_rep_inc;
  logic [REP_W-1:0] w_rep_target;
  logic             w_rep_hit;
  logic             w_rep_evt;

  // Before the first repeat the hold must last REPEAT_DELAY ticks, after it
  // every REPEAT_RATE ticks yields another synthetic press
  assign w_rep_inc    = r_rep_cnt + 1'b1;
  assign w_rep_target = r_rep_armed ? REP_W'(REPEAT_RATE) : REP_W'(REPEAT_DELAY);
  assign w_rep_hit    = (w_rep_inc == w_rep_target);
  assign w_rep_evt    = w_tick & w_stable[KEY] & w_rep_hit;

  // Repeat timer runs on ticks only while the key is held, clears on release
  always_ff @(posedge clock) begin
    if (reset || !w_stable[KEY]) begin
      r_rep_cnt   <= '0;
      r_rep_armed <= 1'b0;
    end else if (w_tick) begin
      if (w_rep_hit) begin
        r_rep_cnt   <= '0;
        r_rep_armed <= 1'b1;
      end else begin
        r_rep_cnt <= w_rep_inc;
      end
    end
  end

  assign w_event = w_press | w_rep_evt;
`else
  assign w_event = w_press;
`endif

  // Holding register: capture on press, release on ack, flag lost presses.
  // A press coinciding with an ack replaces the snapshot and keeps it valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (w_event) begin
      if (!r_data_valid) begin
        r_data_out   <= w_stable[15:0];
        r_data_valid <= 1'b1;
      end else if (data_ack) begin
        r_data_out <= w_stable[15:0];
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (data_ack && r_data_valid) begin
      r_data_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end
  end

  assign sw          = w_stable[15:0];
  assign key_pressed = w_stable[KEY];
  assign data_out    = r_data_out;
  assign data_valid  = r_data_valid;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_switch_input_conditioner.sv
// Testbench for switch_input_conditioner: directed scenarios followed by a
// randomized phase, every cycle compared against a tick-history reference model.
module tb_switch_input_conditioner;

  localparam int TICK_DIV = 4;
  localparam int DB       = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] sw_raw = 16'h0000;
  logic        key_raw = 1'b1;
  logic        data_ack = 1'b0;
  logic [15:0] sw;
  logic        key_pressed;
  logic [15:0] data_out;
  logic        data_valid;
  logic        overrun;

  switch_input_conditioner #(
    .TICK_DIV      (TICK_DIV),
    .DEBOUNCE_TICKS(DB),
    .KEY_ACTIVE_LOW(1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .sw_raw     (sw_raw),
    .key_raw    (key_raw),
    .sw         (sw),
    .key_pressed(key_pressed),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ack   (data_ack),
    .overrun    (overrun)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: raw history through the synchroniser, the list of
  // recent tick samples, and per-channel sample age since the last level change
  logic [16:0] m_s1, m_s2, m_stable;
  int          m_phase;
  int          m_age [17];
  logic [16:0] m_hist [$];
  logic        m_prev_key;
  logic [15:0] m_dout;
  logic        m_valid, m_ovr;
  int          m_tick_hits;

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance the model across one clock edge using the inputs present before it
  task automatic model_edge();
    logic [16:0] smp;
    logic        press;
    logic        all_diff;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_phase = 0;
      foreach (m_age[c]) m_age[c] = 0;
      m_hist.delete();
      m_prev_key = 1'b0; m_dout = '0; m_valid = 1'b0; m_ovr = 1'b0;
    end else begin
      press = m_stable[16] & ~m_prev_key;
      if (press) begin
        if (!m_valid) begin
          m_dout = m_stable[15:0]; m_valid = 1'b1;
        end else if (data_ack) begin
          m_dout = m_stable[15:0];
        end else begin
          m_ovr = 1'b1;
        end
      end else if (data_ack && m_valid) begin
        m_valid = 1'b0; m_ovr = 1'b0;
      end
      m_prev_key = m_stable[16];
      if (m_phase == TICK_DIV - 1) begin
        smp = {~m_s2[16], m_s2[15:0]};
        m_hist.push_back(smp);
        if (m_hist.size() > DB) void'(m_hist.pop_front());
        if (smp[0]) m_tick_hits++;
        for (int ch = 0; ch < 17; ch++) begin
          if (m_age[ch] < DB) m_age[ch]++;
          all_diff = (m_age[ch] >= DB);
          for (int k = 0; k < m_hist.size(); k++)
            if (m_hist[k][ch] == m_stable[ch]) all_diff = 1'b0;
          if (all_diff) begin
            m_stable[ch] = ~m_stable[ch];
            m_age[ch] = 0;
          end
        end
        m_phase = 0;
      end else begin
        m_phase++;
      end
      m_s2 = m_s1;
      m_s1 = {key_raw, sw_raw};
    end
  endtask

  // One clock cycle with full output comparison against the model
  task automatic cyc();
    model_edge();
    @(posedge clock);
    #1;
    chk16("sw", sw, m_stable[15:0]);
    chk1("key_pressed", key_pressed, m_stable[16]);
    chk16("data_out", data_out, m_dout);
    chk1("data_valid", data_valid, m_valid);
    chk1("overrun", overrun, m_ovr);
  endtask

  task automatic press_release();
    key_raw = 1'b0;
    repeat (20) cyc();
    key_raw = 1'b1;
    repeat (20) cyc();
  endtask

  initial begin
    logic seen;
    m_tick_hits = 0;

    // Reset, then idle with A5C3 on the switches
    sw_raw = 16'hA5C3; key_raw = 1'b1; reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk16("rst_sw", sw, 16'h0000);
    chk16("rst_data_out", data_out, 16'h0000);
    chk1("rst_valid", data_valid, 1'b0);
    chk1("rst_overrun", overrun, 1'b0);
    chk1("rst_key", key_pressed, 1'b0);
    repeat (11) cyc();
    chk16("t1_sw_before_3_ticks", sw, 16'h0000);
    cyc();
    chk16("t1_sw_after_3_ticks", sw, 16'hA5C3);
    $display("T1 idle settle: sw=%h valid=%b overrun=%b", sw, data_valid, overrun);

    // Glitch of 2 ticks on bit 4 is rejected
    sw_raw = 16'hA5D3;
    repeat (8) cyc();
    sw_raw = 16'hA5C3;
    repeat (20) cyc();
    chk1("t2_glitch_2_ticks", sw[4], 1'b0);
    // 3-tick pulse is accepted, then returning low for 3 ticks clears it
    sw_raw = 16'hA5D3;
    repeat (12) cyc();
    sw_raw = 16'hA5C3;
    repeat (2) cyc();
    chk1("t2_pulse_3_ticks", sw[4], 1'b1);
    repeat (14) cyc();
    chk1("t2_return_low", sw[4], 1'b0);
    $display("T2 glitch/pulse: sw=%h", sw);

    // Single press captures 1234, ack releases it
    sw_raw = 16'h1234;
    repeat (20) cyc();
    press_release();
    chk1("t3_valid", data_valid, 1'b1);
    chk16("t3_data_out", data_out, 16'h1234);
    data_ack = 1'b1; cyc(); data_ack = 1'b0;
    chk1("t3_valid_after_ack", data_valid, 1'b0);
    chk16("t3_data_hold", data_out, 16'h1234);
    $display("T3 press/ack: data_out=%h valid=%b", data_out, data_valid);

    // Two presses without ack: first snapshot kept, overrun set
    sw_raw = 16'h0001;
    repeat (20) cyc();
    press_release();
    sw_raw = 16'h0002;
    repeat (20) cyc();
    press_release();
    chk16("t4_data_out", data_out, 16'h0001);
    chk1("t4_overrun", overrun, 1'b1);
    chk1("t4_valid", data_valid, 1'b1);
    data_ack = 1'b1; cyc(); data_ack = 1'b0;
    chk1("t4_valid_after_ack", data_valid, 1'b0);
    chk1("t4_overrun_after_ack", overrun, 1'b0);
    $display("T4 overrun: data_out=%h overrun=%b", data_out, overrun);

    // Press coincident with ack while valid replaces the snapshot
    sw_raw = 16'h00FF;
    repeat (20) cyc();
    press_release();
    chk16("t5_old_data", data_out, 16'h00FF);
    sw_raw = 16'hFF00;
    repeat (20) cyc();
    key_raw = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cyc();
      if (key_pressed === 1'b1) seen = 1'b1;
    end
    chk1("t5_key_seen_in_budget", seen, 1'b1);
    data_ack = 1'b1; cyc(); data_ack = 1'b0;
    chk1("t5_valid", data_valid, 1'b1);
    chk16("t5_data_out", data_out, 16'hFF00);
    chk1("t5_overrun", overrun, 1'b0);
    key_raw = 1'b1;
    repeat (20) cyc();
    $display("T5 press+ack: data_out=%h valid=%b overrun=%b", data_out, data_valid, overrun);

    // Reset with data pending and bit 0 two ticks into its debounce
    sw_raw = 16'hFF01;
    m_tick_hits = 0;
    for (int i = 0; i < 40 && m_tick_hits < 2; i++) cyc();
    chk1("t6_two_ticks_in_budget", (m_tick_hits == 2), 1'b1);
    chk16("t6_sw_not_yet", sw, 16'hFF00);
    reset = 1'b1; cyc(); reset = 1'b0;
    chk16("t6_rst_sw", sw, 16'h0000);
    chk16("t6_rst_data_out", data_out, 16'h0000);
    chk1("t6_rst_valid", data_valid, 1'b0);
    chk1("t6_rst_overrun", overrun, 1'b0);
    repeat (11) cyc();
    chk16("t6_sw_before_3_ticks", sw, 16'h0000);
    cyc();
    chk16("t6_sw_after_3_ticks", sw, 16'hFF01);
    $display("T6 reset mid-debounce: sw=%h", sw);

    // Randomized switches, key and acks against the model
    for (int r = 0; r < 300; r++) begin
      int hold;
      case ($urandom_range(0, 3))
        0: sw_raw = 16'($urandom);
        1: sw_raw = sw_raw ^ (16'd1 << $urandom_range(0, 15));
        2: key_raw = ~key_raw;
        default: ;
      endcase
      hold = $urandom_range(1, 24);
      for (int h = 0; h < hold; h++) begin
        data_ack = ($urandom_range(0, 31) == 0);
        cyc();
      end
    end
    data_ack = 1'b0;
    $display("T7 random: sw=%h data_out=%h valid=%b overrun=%b", sw, data_out, data_valid, overrun);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/switch_input_conditioner.md
Name: switch_input_conditioner

Overview:
- Sits directly upstream of the processor's IO input path. It conditions the raw board switches and the "enter" push-button before the processor consumes them.
- Synchronises and debounces 16 switches plus one key. Presents the stable switch word continuously.
- On each debounced key press, captures a snapshot of the switches into a valid/ack holding register. The processor's input instruction consumes the snapshot through this register.

Parameters:
- TICK_DIV, 50000: clock cycles per debounce sample tick (1 ms at 50 MHz); legal range >= 2.
- DEBOUNCE_TICKS, 10: consecutive equal samples required before a channel's stable value changes; legal range >= 1.
- KEY_ACTIVE_LOW, 1: 1 = key_raw is low when pressed (board convention); 0 = high when pressed.

Ports:
- clock  input  1  system clock, single clock domain.
- reset  input  1  synchronous, active-high reset.
- sw_raw  input  16  asynchronous board switches.
- key_raw  input  1  asynchronous enter button, polarity per KEY_ACTIVE_LOW.
- sw  output  16  debounced switch levels.
- key_pressed  output  1  debounced key level, normalised so that 1 = pressed.
- data_out  output  16  switch snapshot taken at the last accepted press.
- data_valid  output  1  data_out holds an unconsumed snapshot.
- data_ack  input  1  consumer accepts data_out; only meaningful while data_valid=1.
- overrun  output  1  sticky flag: a press was lost while data_valid=1.

Behaviour:
- Reset (synchronous, any cycle, including mid-debounce or with data pending) clears the following: sync flops, prescaler, all per-channel counters, sw=0, key_pressed=0, data_out=0, data_valid=0, overrun=0.
- Synchroniser: two flops per channel (17 channels). key_raw is inverted after sync when KEY_ACTIVE_LOW=1.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 for exactly one cycle when the count equals TICK_DIV-1. The first tick after reset falls on cycle TICK_DIV.
- Per-channel debounce, evaluated only on tick:
  - If sample == stable, the channel counter is cleared to 0.
  - Otherwise the counter increments. When the incremented value reaches DEBOUNCE_TICKS, stable <= sample and the counter clears.
  - Counter width is $clog2(DEBOUNCE_TICKS+1).
  - A glitch shorter than DEBOUNCE_TICKS ticks never changes stable.
  - Latency from a settled input to a stable change: 2 sync cycles plus up to DEBOUNCE_TICKS ticks, the last of which registers one cycle after the tick.
- Press event: one-cycle internal pulse when key_pressed goes 0->1. Release generates no event.
- Holding register, updated each cycle:
  - Press and data_valid=0: data_out <= sw. The snapshot is taken in the same cycle as the press pulse and includes any sw update in that cycle. data_valid <= 1 on the next edge.
  - Press, data_valid=1, data_ack=1 (simultaneous): data_out <= new sw, data_valid stays 1, overrun unchanged.
  - Press, data_valid=1, data_ack=0: data_out unchanged, overrun <= 1.
  - No press, data_ack=1, data_valid=1: data_valid <= 0. data_out holds its value.
  - data_ack while data_valid=0: ignored.
- overrun clears only on reset or on an ack that is not coincident with a press.
- All outputs are registered. The block contains no combinational path from any input to any output.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined: adds parameters REPEAT_DELAY (default 500) and REPEAT_RATE (default 100), both in ticks.
  - While key_pressed=1, a repeat counter runs on ticks.
  - After REPEAT_DELAY ticks held, a synthetic press event is generated, then another every REPEAT_RATE ticks.
  - Synthetic events follow the same holding-register rules as real presses, including overrun.
  - The counter clears on release or reset.
- Undefined: no repeat logic is synthesised. Only 0->1 transitions of key_pressed produce events.

Test Plan:
Parameters TICK_DIV=4, DEBOUNCE_TICKS=3, KEY_ACTIVE_LOW=1 unless stated.
- Reset, then idle with sw_raw=16'hA5C3 -> sw=16'h0000 until 3 ticks after sync, then sw=16'hA5C3. data_valid=0 and overrun=0 throughout.
- sw_raw bit 4 pulsed high for 2 ticks only -> sw[4] stays 0. A 3-tick pulse -> sw[4]=1. Returning low for 3 ticks -> sw[4]=0.
- sw settled at 16'h1234, key_raw held 0 for 5 ticks -> data_valid=1, data_out=16'h1234. data_ack for 1 cycle -> data_valid=0 with data_out still 16'h1234.
- Two presses without ack (sw 16'h0001, then 16'h0002) -> data_out=16'h0001, overrun=1. A subsequent ack -> data_valid=0, overrun=0.
- Press coinciding in the same cycle with data_ack while valid (old 16'h00FF, sw=16'hFF00) -> data_valid stays 1, data_out=16'hFF00, overrun=0.
- Reset asserted for one cycle with data_valid=1 and a channel counter at 2 -> next cycle all outputs 0, and the channel requires 3 fresh ticks to change.
